// File: rtl/alu_seq_pkg.sv
// Shared definitions for the nibble-sequenced ALU: opcodes, FSM encoding,
// flag bit positions and a small opcode classifier.
package alu_seq_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned FLG_W = 4;

  // Opcode encoding
  localparam logic [OP_W-1:0] OP_AND  = 3'b000;
  localparam logic [OP_W-1:0] OP_OR   = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
  localparam logic [OP_W-1:0] OP_NOTA = 3'b011;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b100;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b101;
  localparam logic [OP_W-1:0] OP_NAND = 3'b110;
  localparam logic [OP_W-1:0] OP_NOR  = 3'b111;

  // Flag bit positions within out_flags
  localparam int unsigned FLG_ZERO  = 0;
  localparam int unsigned FLG_CARRY = 1;
  localparam int unsigned FLG_NEG   = 2;
  localparam int unsigned FLG_OVF   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // True for opcodes that use the carry chain
  function automatic logic is_arith(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/logic_slice_4.sv
// Combinational 4-bit ALU slice.
// Ports: a, b (4-bit operands), op (opcode), cin (carry in)
//        y (4-bit result), cout (carry out, 0 for logic ops),
//        c_top (carry into bit 3, used for signed overflow).
module logic_slice_4
  import alu_seq_pkg::*;
(
  input  logic [3:0]      a,
  input  logic [3:0]      b,
  input  logic [OP_W-1:0] op,
  input  logic            cin,
  output logic [3:0]      y,
  output logic            cout,
  output logic            c_top
);

  logic [3:0] w_b_eff;
  logic [4:0] w_sum;

  // SUB is A + ~B + cin, with cin seeded to 1 on the first nibble
  always_comb begin
    w_b_eff = (op == OP_SUB) ? ~b : b;
    w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {4'b0000, cin};
    c_top   = a[3] ^ w_b_eff[3] ^ w_sum[3];
    y       = 4'h0;
    cout    = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOTA: y = ~a;
      OP_ADD,
      OP_SUB: begin
        y    = w_sum[3:0];
        cout = w_sum[4];
      end
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      default: y = 4'h0;
    endcase
  end

endmodule

// File: rtl/alu_nibble_seq.sv
// Sequential WIDTH-bit ALU that runs one 4-bit slice over the operand
// nibbles LSB first, rippling carry between passes.
// Ports: clk, rst (sync, active-high)
//        in_valid/in_ready/in_a/in_b/in_op : operand transaction
//        out_valid/out_ready/out_res/out_flags : result {ovf,neg,carry,zero}
// Build option: define ALU_SEQ_FLAGS_EN to compute out_flags; otherwise
// out_flags is tied to zero.
module alu_nibble_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [FLG_W-1:0] out_flags
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned LAST   = NSLICE - 1;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_a, w_a_nxt;
  logic [WIDTH-1:0] r_b, w_b_nxt;
  logic [OP_W-1:0]  r_op, w_op_nxt;
  logic             r_carry, w_carry_nxt;
  logic [WIDTH-1:0] r_acc, w_acc_nxt;
  logic [WIDTH-1:0] r_res, w_res_nxt;
  logic             r_in_ready, w_in_ready_nxt;
  logic             r_out_valid, w_out_valid_nxt;

  logic [SLICE-1:0] w_y;
  logic             w_cout;
  logic             w_ctop;
  logic [WIDTH-1:0] w_res_full;
  logic             w_last;

  // Operands shift right one nibble per pass, so the slice always sees bit 0 up
  logic_slice_4 u_slice (
    .a     (r_a[SLICE-1:0]),
    .b     (r_b[SLICE-1:0]),
    .op    (r_op),
    .cin   (r_carry),
    .y     (w_y),
    .cout  (w_cout),
    .c_top (w_ctop)
  );

  // Result nibbles enter at the top and shift down; after NSLICE passes they are in place
  assign w_res_full = {w_y, r_acc[WIDTH-1:SLICE]};
  assign w_last     = (r_state == CALC) && (r_cnt == CNT_W'(LAST));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= OP_AND;
      r_carry     <= 1'b0;
      r_acc       <= '0;
      r_res       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_op        <= w_op_nxt;
      r_carry     <= w_carry_nxt;
      r_acc       <= w_acc_nxt;
      r_res       <= w_res_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_op_nxt        = r_op;
    w_carry_nxt     = r_carry;
    w_acc_nxt       = r_acc;
    w_res_nxt       = r_res;
    w_in_ready_nxt  = r_in_ready;
    w_out_valid_nxt = r_out_valid;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_a_nxt        = in_a;
          w_b_nxt        = in_b;
          w_op_nxt       = in_op;
          w_carry_nxt    = (in_op == OP_SUB);
          w_cnt_nxt      = '0;
          w_in_ready_nxt = 1'b0;
          w_state_nxt    = CALC;
        end
      end
      CALC: begin
        w_a_nxt     = r_a >> SLICE;
        w_b_nxt     = r_b >> SLICE;
        w_acc_nxt   = w_res_full;
        w_carry_nxt = w_cout;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        if (w_last) begin
          w_res_nxt       = w_res_full;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_in_ready_nxt  = 1'b1;
          w_state_nxt     = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic [FLG_W-1:0] r_flags;
  logic [FLG_W-1:0] w_flags_calc;

  // Flags from the fully assembled result and the top slice's carries
  always_comb begin
    w_flags_calc            = '0;
    w_flags_calc[FLG_ZERO]  = (w_res_full == '0);
    w_flags_calc[FLG_NEG]   = w_res_full[WIDTH-1];
    if (is_arith(r_op)) begin
      w_flags_calc[FLG_CARRY] = w_cout;
      w_flags_calc[FLG_OVF]   = w_cout ^ w_ctop;
    end
  end

  // Flags load together with out_res on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= '0;
    end else if (w_last) begin
      r_flags <= w_flags_calc;
    end
  end

  assign out_flags = r_flags;
`else
  logic w_unused_ctop;
  assign w_unused_ctop = w_ctop;
  assign out_flags     = '0;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_res   = r_res;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed testbench for alu_nibble_seq.
module tb_alu_nibble_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [2:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_res;
  logic [3:0] out_flags;

  int vectors     = 0;
  int miscompares = 0;

  alu_nibble_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_flags (out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected flags depend on whether the flag feature is built in
  function automatic logic [3:0] xf(input logic [3:0] f);
`ifdef ALU_SEQ_FLAGS_EN
    return f;
`else
    return 4'h0 & f;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and check it reaches DONE exactly 3 cycles after accept
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic [7:0] er, input logic [3:0] ef);
    chk({tag, "/rdy_pre"}, 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_a = ~a; in_b = 8'h5A; in_op = ~op;
    chk({tag, "/rdy_c1"}, 32'(in_ready), 32'd0);
    chk({tag, "/vld_c1"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, "/vld_c2"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, "/vld_c3"}, 32'(out_valid), 32'd1);
    chk({tag, "/res"}, 32'(out_res), 32'(er));
    chk({tag, "/flags"}, 32'(out_flags), 32'(xf(ef)));
  endtask

  task automatic release_op(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "/vld_rel"}, 32'(out_valid), 32'd0);
    chk({tag, "/rdy_rel"}, 32'(in_ready), 32'd1);
  endtask

  int         acc_cyc[2];
  logic [7:0] got_res[2];
  logic [3:0] got_fl[2];
  int         nacc;
  int         nres;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_op = 3'b000; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset/in_ready", 32'(in_ready), 32'd1);
    chk("reset/out_valid", 32'(out_valid), 32'd0);
    chk("reset/out_res", 32'(out_res), 32'd0);
    chk("reset/out_flags", 32'(out_flags), 32'd0);

    // flags = {ovf, neg, carry, zero}
    run_op("and", 8'hA5, 8'h3C, 3'b000, 8'h24, 4'b0000);
    release_op("and");
    run_op("add", 8'hFF, 8'h01, 3'b100, 8'h00, 4'b0011);
    release_op("add");
    run_op("sub_ovf", 8'h80, 8'h01, 3'b101, 8'h7F, 4'b1010);
    release_op("sub_ovf");
    run_op("sub_brw", 8'h00, 8'h01, 3'b101, 8'hFF, 4'b0100);
    release_op("sub_brw");

    // Backpressure: result held while out_ready stays low
    run_op("nor", 8'h0F, 8'hF0, 3'b111, 8'h00, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp/out_valid", 32'(out_valid), 32'd1);
      chk("bp/out_res", 32'(out_res), 32'h00);
      chk("bp/out_flags", 32'(out_flags), 32'(xf(4'b0001)));
      chk("bp/in_ready", 32'(in_ready), 32'd0);
    end
    release_op("nor");

    // Load a non-zero result so the abort's clearing of out_res is visible
    run_op("nand", 8'hF0, 8'h3C, 3'b110, 8'hCF, 4'b0100);
    release_op("nand");

    // Reset in the second CALC cycle aborts the operation
    in_a = 8'h12; in_b = 8'h34; in_op = 3'b100; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort/in_ready", 32'(in_ready), 32'd1);
    chk("abort/out_valid", 32'(out_valid), 32'd0);
    chk("abort/out_res", 32'(out_res), 32'h00);
    chk("abort/out_flags", 32'(out_flags), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort/no_result", 32'(out_valid), 32'd0);
    end

    // Back-to-back with in_valid held and out_ready always high
    nacc = 0; nres = 0;
    acc_cyc[0] = -100; acc_cyc[1] = 100;
    got_res[0] = 8'h00; got_res[1] = 8'h00; got_fl[0] = 4'h0; got_fl[1] = 4'h0;
    in_a = 8'h55; in_b = 8'hFF; in_op = 3'b010; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (in_valid && in_ready && nacc < 2) begin
        acc_cyc[nacc] = c;
        nacc++;
      end
      if (out_valid && nres < 2) begin
        got_res[nres] = out_res;
        got_fl[nres]  = out_flags;
        nres++;
      end
      tick();
      if (nacc == 1) begin
        in_a = 8'h0F; in_b = 8'h00; in_op = 3'b011;
      end else if (nacc == 2) begin
        in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    chk("b2b/accepts", 32'(nacc), 32'd2);
    chk("b2b/results", 32'(nres), 32'd2);
    chk("b2b/spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
    chk("b2b/res0", 32'(got_res[0]), 32'hAA);
    chk("b2b/flags0", 32'(got_fl[0]), 32'(xf(4'b0100)));
    chk("b2b/res1", 32'(got_res[1]), 32'hF0);
    chk("b2b/flags1", 32'(got_fl[1]), 32'(xf(4'b0100)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
